vregfile_wbarb: RTL and testbench
=================================

VREGFILE_WBARB -- requirements
Module: vregfile_wbarb

Interface
REQ-001 SHALL have parameter NUMBANKS, default 1, number of register-file banks.
REQ-002 SHALL have parameter LOG2NUMREGSPERBANK, default 5, register address width per bank.
REQ-003 SHALL have parameter WIDTH, default 32, data bits per bank; values below 8 are illegal.
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports r0_valid/r1_valid, input, 1, requester N (0=ALU, 1=memory) offers a writeback beat.
REQ-007 SHALL have ports r0_ready/r1_ready, output, 1, requester N beat accepted this cycle.
REQ-008 SHALL have ports r0_last/r1_last, input, 1, final beat of the requester's burst.
REQ-009 SHALL have ports r0_reg/r1_reg, input, NUMBANKS*LOG2NUMREGSPERBANK, per-bank destination register.
REQ-010 SHALL have ports r0_data/r1_data, input, NUMBANKS*WIDTH, per-bank write data.
REQ-011 SHALL have ports r0_byteen/r1_byteen, input, NUMBANKS*WIDTH/8, per-bank byte enables.
REQ-012 SHALL have ports r0_bankmask/r1_bankmask, input, NUMBANKS, banks written by the beat.
REQ-013 SHALL have ports c_reg, c_writedatain, c_byteen and c_we, outputs, widths as REQ-009 to REQ-012, the register-file write port.
REQ-014 SHALL have port busy, output, 1, a burst owns the write port.

Function
REQ-015 A beat SHALL be accepted when rN_valid and rN_ready are both 1; rN_ready SHALL be combinational from the state, valids, lasts and bankmasks only.
REQ-016 An accepted beat SHALL appear on c_* exactly 1 cycle later, with c_we equal to its bankmask.
REQ-017 In a cycle after no accept, c_we SHALL be 0 and c_reg/c_writedatain/c_byteen SHALL hold their previous values.
REQ-018 The FSM SHALL have exactly the states IDLE, OWN0 and OWN1; busy SHALL be 1 in OWN0 and OWN1.
REQ-019 In IDLE with exactly one valid, that requester SHALL be granted.
REQ-020 In IDLE with both valid, the requester named by the 1-bit round-robin pointer rr SHALL be granted.
REQ-021 When a beat is accepted in IDLE with last=0, the FSM SHALL move to OWNn; when last=1, it SHALL stay in IDLE.
REQ-022 In OWNn only rn_ready SHALL be able to be 1; the other requester SHALL wait regardless of its valid.
REQ-023 In OWNn with rn_valid=0, the FSM SHALL hold state and no write SHALL occur.
REQ-024 Acceptance of a last=1 beat from requester n SHALL set rr to the other requester and return the FSM to IDLE.
REQ-025 A beat with bankmask=0 SHALL be consumed normally, including its last handling, with c_we=0.
REQ-026 Without merge, r0_ready and r1_ready SHALL never both be 1.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, rr=0, c_we=0, c_reg=0, c_writedatain=0, c_byteen=0 and busy=0.
REQ-028 A burst in progress at reset SHALL be abandoned; no beat is replayed after reset.

Configuration
REQ-029 With VREGFILE_WBARB_MERGE_EN defined, in IDLE with both valid, both last=1 and (r0_bankmask & r1_bankmask)==0, both readies SHALL be 1.
REQ-030 A merged cycle SHALL drive each bank's c_* fields from the requester owning that bank, set c_we to the OR of both masks, and leave rr unchanged.
REQ-031 Without VREGFILE_WBARB_MERGE_EN, behaviour SHALL be exactly REQ-019 to REQ-026 and no merge logic SHALL exist.

Structure
REQ-032 Package vregfile_pkg SHALL hold the FSM state typedef (IDLE/OWN0/OWN1) and the default WIDTH/NUMBANKS/LOG2NUMREGSPERBANK constants.
REQ-033 The round-robin grant pick SHALL be one combinational sub-module, vregfile_wbarb_rrpick; the FSM and output register SHALL stay in the top module.

Verification
REQ-034 Scenario: reset then r0 beat reg=3, data=0xDEADBEEF, mask=1, last=1 -> r0_ready=1; next cycle c_we=1, c_reg=3, c_writedatain=0xDEADBEEF.
REQ-035 Scenario: both valid in IDLE after reset, last=1 -> r0 granted (rr=0); repeat -> r1 granted; repeat -> r0 granted.
REQ-036 Scenario: r1 3-beat burst (last on beat 3) with r0 continuously valid -> r0_ready=0 until r1's third beat is accepted, busy=1 for those cycles, r0 granted next.
REQ-037 Scenario: reset asserted in OWN1 after beat 1 -> same cycle c_we=0 and busy=0; after release, r0-only valid is granted.
REQ-038 Scenario with VREGFILE_WBARB_MERGE_EN and NUMBANKS=4: r0 mask=4'b0011, r1 mask=4'b1100, both last=1 -> both ready, next-cycle c_we=4'b1111 with per-bank data from the owners; same with overlapping masks -> only one ready.

Source files
------------

// File: rtl/vregfile_pkg.sv
// vregfile_pkg: default geometry and the arbiter FSM state type.
package vregfile_pkg;
  localparam int DEF_NUMBANKS = 1;
  localparam int DEF_LOG2NUMREGSPERBANK = 5;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
endpackage

// File: rtl/vregfile_wbarb_if.sv
// vregfile_wbarb_if: two writeback requesters plus the register-file write port.
interface vregfile_wbarb_if import vregfile_pkg::*; #(
  parameter int NUMBANKS = DEF_NUMBANKS,
  parameter int LOG2NUMREGSPERBANK = DEF_LOG2NUMREGSPERBANK,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int RW = NUMBANKS*LOG2NUMREGSPERBANK;
  localparam int DW = NUMBANKS*WIDTH;
  localparam int BW = NUMBANKS*WIDTH/8;
  logic r0_valid, r0_ready, r0_last, r1_valid, r1_ready, r1_last;
  logic [RW-1:0] r0_reg, r1_reg, c_reg;
  logic [DW-1:0] r0_data, r1_data, c_writedatain;
  logic [BW-1:0] r0_byteen, r1_byteen, c_byteen;
  logic [NUMBANKS-1:0] r0_bankmask, r1_bankmask, c_we;
  logic busy;
  modport slave(
    input r0_valid, r0_last, r0_reg, r0_data, r0_byteen, r0_bankmask,
    input r1_valid, r1_last, r1_reg, r1_data, r1_byteen, r1_bankmask,
    output r0_ready, r1_ready, c_reg, c_writedatain, c_byteen, c_we, busy
  );
  modport master(
    output r0_valid, r0_last, r0_reg, r0_data, r0_byteen, r0_bankmask,
    output r1_valid, r1_last, r1_reg, r1_data, r1_byteen, r1_bankmask,
    input r0_ready, r1_ready, c_reg, c_writedatain, c_byteen, c_we, busy
  );
endinterface

// File: rtl/vregfile_wbarb_rrpick.sv
// vregfile_wbarb_rrpick: combinational grant pick; VREGFILE_WBARB_MERGE_EN adds
// dual grant for disjoint single-beat writes.
module vregfile_wbarb_rrpick import vregfile_pkg::*; (
  input state_t state,
  input logic rr,
  input logic [1:0] valid,
`ifdef VREGFILE_WBARB_MERGE_EN
  input logic [1:0] last,
  input logic disjoint,
`endif
  output logic [1:0] ready
);
  always_comb begin
    ready = state == OWN0 ? {1'b0, valid[0]} :
            state == OWN1 ? {valid[1], 1'b0} :
            &valid ? (rr ? 2'b10 : 2'b01) : valid;
`ifdef VREGFILE_WBARB_MERGE_EN
    if (state == IDLE && &valid && &last && disjoint) ready = 2'b11;
`endif
  end
endmodule

// File: rtl/vregfile_wbarb.sv
// vregfile_wbarb: burst-aware round-robin writeback arbiter for a banked register file.
// Optional VREGFILE_WBARB_MERGE_EN merges disjoint-bank single beats into one write.
module vregfile_wbarb import vregfile_pkg::*; #(
  parameter int NUMBANKS = DEF_NUMBANKS,
  parameter int LOG2NUMREGSPERBANK = DEF_LOG2NUMREGSPERBANK,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic reset,
  vregfile_wbarb_if.slave bus
);
  localparam int LR = LOG2NUMREGSPERBANK;
  localparam int BB = WIDTH/8;
  state_t state;
  logic rr, merged;
  logic [1:0] ready;
  logic [NUMBANKS*LR-1:0] nxt_reg;
  logic [NUMBANKS*WIDTH-1:0] nxt_data;
  logic [NUMBANKS*BB-1:0] nxt_byteen;
  vregfile_wbarb_rrpick pick (
    .state(state),
    .rr(rr),
    .valid({bus.r1_valid, bus.r0_valid}),
`ifdef VREGFILE_WBARB_MERGE_EN
    .last({bus.r1_last, bus.r0_last}),
    .disjoint(~|(bus.r0_bankmask & bus.r1_bankmask)),
`endif
    .ready(ready)
  );
  assign bus.r0_ready = ready[0];
  assign bus.r1_ready = ready[1];
  assign bus.busy = state != IDLE;
`ifdef VREGFILE_WBARB_MERGE_EN
  assign merged = &ready;
  // banks claimed by r1 come from r1; everything else follows r0
  always_comb begin
    nxt_reg = '0;
    nxt_data = '0;
    nxt_byteen = '0;
    for (int b = 0; b < NUMBANKS; b++) begin
      logic sel;
      sel = ready[1] & (~ready[0] | bus.r1_bankmask[b]);
      nxt_reg[b*LR +: LR] = sel ? bus.r1_reg[b*LR +: LR] : bus.r0_reg[b*LR +: LR];
      nxt_data[b*WIDTH +: WIDTH] = sel ? bus.r1_data[b*WIDTH +: WIDTH] : bus.r0_data[b*WIDTH +: WIDTH];
      nxt_byteen[b*BB +: BB] = sel ? bus.r1_byteen[b*BB +: BB] : bus.r0_byteen[b*BB +: BB];
    end
  end
`else
  assign merged = 1'b0;
  assign nxt_reg = ready[1] ? bus.r1_reg : bus.r0_reg;
  assign nxt_data = ready[1] ? bus.r1_data : bus.r0_data;
  assign nxt_byteen = ready[1] ? bus.r1_byteen : bus.r0_byteen;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b0;
      bus.c_we <= '0;
      bus.c_reg <= '0;
      bus.c_writedatain <= '0;
      bus.c_byteen <= '0;
    end else begin
      bus.c_we <= (ready[0] ? bus.r0_bankmask : '0) | (ready[1] ? bus.r1_bankmask : '0);
      if (|ready) begin
        bus.c_reg <= nxt_reg;
        bus.c_writedatain <= nxt_data;
        bus.c_byteen <= nxt_byteen;
      end
      if (ready[0] && !merged) begin
        state <= bus.r0_last ? IDLE : OWN0;
        if (bus.r0_last) rr <= 1'b1;
      end else if (ready[1] && !merged) begin
        state <= bus.r1_last ? IDLE : OWN1;
        if (bus.r1_last) rr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vregfile_wbarb.sv
// tb_vregfile_wbarb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vregfile_wbarb;
  localparam int NB = 4, LR = 5, W = 32, BB = W/8;
  localparam int RW = NB*LR, DW = NB*W, BW = NB*BB;
`ifdef VREGFILE_WBARB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  vregfile_wbarb_if #(.NUMBANKS(NB), .LOG2NUMREGSPERBANK(LR), .WIDTH(W)) bus();
  vregfile_wbarb #(.NUMBANKS(NB), .LOG2NUMREGSPERBANK(LR), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, fails = 0;
  int m_own;
  bit m_rr;
  logic [RW-1:0] m_reg;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_be;
  logic [NB-1:0] m_we;

  task automatic drive(input bit v0, l0, input logic [NB-1:0] k0, input bit v1, l1, input logic [NB-1:0] k1);
    bus.r0_valid = v0; bus.r0_last = l0; bus.r0_bankmask = k0;
    bus.r1_valid = v1; bus.r1_last = l1; bus.r1_bankmask = k1;
    bus.r0_reg = RW'($urandom); bus.r1_reg = RW'($urandom);
    bus.r0_data = {$urandom, $urandom, $urandom, $urandom};
    bus.r1_data = {$urandom, $urandom, $urandom, $urandom};
    bus.r0_byteen = BW'($urandom); bus.r1_byteen = BW'($urandom);
  endtask

  function automatic logic [1:0] model_ready();
    bit v0 = bus.r0_valid, v1 = bus.r1_valid;
    if (m_own == 0) return {1'b0, v0};
    if (m_own == 1) return {v1, 1'b0};
    if (v0 && v1) begin
      if (MERGE && bus.r0_last && bus.r1_last && (bus.r0_bankmask & bus.r1_bankmask) == '0) return 2'b11;
      return m_rr ? 2'b10 : 2'b01;
    end
    return {v1, v0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_own = -1; m_rr = 1'b0; m_reg = '0; m_data = '0; m_be = '0; m_we = '0;
  endtask

  task automatic tick();
    logic [1:0] a;
    a = model_ready();
    @(posedge clk);
    m_we = (a[0] ? bus.r0_bankmask : '0) | (a[1] ? bus.r1_bankmask : '0);
    if (a == 2'b11) begin
      for (int b = 0; b < NB; b++) begin
        bit s = bus.r1_bankmask[b];
        m_reg[b*LR +: LR] = s ? bus.r1_reg[b*LR +: LR] : bus.r0_reg[b*LR +: LR];
        m_data[b*W +: W] = s ? bus.r1_data[b*W +: W] : bus.r0_data[b*W +: W];
        m_be[b*BB +: BB] = s ? bus.r1_byteen[b*BB +: BB] : bus.r0_byteen[b*BB +: BB];
      end
    end else if (a[0]) begin
      m_reg = bus.r0_reg; m_data = bus.r0_data; m_be = bus.r0_byteen;
      if (bus.r0_last) begin m_own = -1; m_rr = 1'b1; end else m_own = 0;
    end else if (a[1]) begin
      m_reg = bus.r1_reg; m_data = bus.r1_data; m_be = bus.r1_byteen;
      if (bus.r1_last) begin m_own = -1; m_rr = 1'b0; end else m_own = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.c_we, bus.c_reg, bus.c_writedatain, bus.c_byteen, bus.busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%h reg=%h data=%h be=%h busy=%b, want all zero",
               bus.c_we, bus.c_reg, bus.c_writedatain, bus.c_byteen, bus.busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 1, 4'b0001, 0, 0, '0);
    bus.r0_reg[LR-1:0] = 5'd3;
    bus.r0_data[W-1:0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.r0_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", bus.r0_ready); end
    tick();
    checks++;
    if (bus.c_we !== 4'b0001 || bus.c_reg[LR-1:0] !== 5'd3 || bus.c_writedatain[W-1:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_write: got we=%b reg=%0d data=%h want we=0001 reg=3 data=deadbeef",
               bus.c_we, bus.c_reg[LR-1:0], bus.c_writedatain[W-1:0]);
    end
    drive(0, 0, '0, 0, 0, '0);
    tick();
    checks++;
    if (bus.c_we !== '0 || bus.c_writedatain[W-1:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL idle_hold: got we=%b data=%h want we=0 data=deadbeef", bus.c_we, bus.c_writedatain[W-1:0]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want [3] = '{2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b0001, 1, 1, 4'b0001);
      #1;
      checks++;
      if ({bus.r1_ready, bus.r0_ready} !== want[i]) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b want %b", i, {bus.r1_ready, bus.r0_ready}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_burst();
    do_reset();
    drive(1, 1, 4'b0001, 0, 0, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b0010, 1, i == 2, 4'b0100);
      #1;
      checks++;
      if ({bus.r1_ready, bus.r0_ready} !== 2'b10 || bus.busy !== (i != 0)) begin
        fails++;
        $display("FAIL burst_beat%0d: got ready=%b busy=%b want ready=10 busy=%b",
                 i, {bus.r1_ready, bus.r0_ready}, bus.busy, i != 0);
      end
      tick();
    end
    drive(1, 1, 4'b0010, 1, 1, 4'b0010);
    #1;
    checks++;
    if ({bus.r1_ready, bus.r0_ready} !== 2'b01 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL burst_after: got ready=%b busy=%b want ready=01 busy=0", {bus.r1_ready, bus.r0_ready}, bus.busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(0, 0, '0, 1, 0, 4'b1000);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.c_we !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got we=%b busy=%b want we=0 busy=0", bus.c_we, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    m_own = -1; m_rr = 1'b0; m_reg = '0; m_data = '0; m_be = '0; m_we = '0;
    drive(1, 1, 4'b0001, 0, 0, '0);
    #1;
    checks++;
    if ({bus.r1_ready, bus.r0_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_regrant: got %b want 01", {bus.r1_ready, bus.r0_ready});
    end
    tick();
  endtask

  task automatic test_merge();
    do_reset();
    drive(1, 1, 4'b0011, 1, 1, 4'b1100);
    #1;
    checks++;
    if ({bus.r1_ready, bus.r0_ready} !== (MERGE ? 2'b11 : 2'b01)) begin
      fails++;
      $display("FAIL merge_ready: got %b want %b", {bus.r1_ready, bus.r0_ready}, MERGE ? 2'b11 : 2'b01);
    end
    tick();
    checks++;
    if (bus.c_we !== (MERGE ? 4'b1111 : 4'b0011) || bus.c_writedatain !== m_data || bus.c_reg !== m_reg) begin
      fails++;
      $display("FAIL merge_write: got we=%b data=%h want we=%b data=%h", bus.c_we, bus.c_writedatain, m_we, m_data);
    end
    drive(1, 1, 4'b0011, 1, 1, 4'b0110);
    #1;
    checks++;
    if ({bus.r1_ready, bus.r0_ready} !== (MERGE ? 2'b01 : 2'b10)) begin
      fails++;
      $display("FAIL merge_overlap: got %b want %b", {bus.r1_ready, bus.r0_ready}, MERGE ? 2'b01 : 2'b10);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, NB'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, NB'($urandom));
      if ($urandom_range(0, 5) == 0) begin bus.r0_last = 1'b1; bus.r1_last = 1'b1; end
      #1;
      exp = model_ready();
      checks++;
      if ({bus.r1_ready, bus.r0_ready} !== exp || bus.busy !== (m_own >= 0)) begin
        fails++;
        $display("FAIL rand_ready@%0d: got ready=%b busy=%b want ready=%b busy=%b",
                 n, {bus.r1_ready, bus.r0_ready}, bus.busy, exp, m_own >= 0);
      end
      tick();
      checks++;
      if (bus.c_we !== m_we || bus.c_reg !== m_reg || bus.c_writedatain !== m_data || bus.c_byteen !== m_be) begin
        fails++;
        $display("FAIL rand_write@%0d: got we=%b reg=%h be=%h data=%h want we=%b reg=%h be=%h data=%h",
                 n, bus.c_we, bus.c_reg, bus.c_byteen, bus.c_writedatain, m_we, m_reg, m_be, m_data);
      end
    end
  endtask

  initial begin
    drive(0, 0, '0, 0, 0, '0);
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_reset_mid_burst();
    test_merge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
